// File: rtl/alloc_arbiter.sv
// Slot allocator: round-robin grants of the lowest free slot to NUM_REQ requesters,
// with owner-checked frees and a LIST_SIZE-cycle clearing sweep after reset.
module alloc_arbiter #(
  parameter int unsigned LIST_SIZE = 32,
  parameter int unsigned NUM_REQ   = 4
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [NUM_REQ-1:0]             REQ,
  output logic [NUM_REQ-1:0]             GNT,
  output logic [$clog2(LIST_SIZE)-1:0]   GNT_SLOT,
  input  logic                           FREE_VALID,
  input  logic [$clog2(NUM_REQ)-1:0]     FREE_ID,
  input  logic [$clog2(LIST_SIZE)-1:0]   FREE_SLOT,
  output logic                           FREE_ERR,
  output logic [$clog2(LIST_SIZE):0]     FREE_COUNT,
  output logic                           READY
);

  localparam int unsigned SW = $clog2(LIST_SIZE);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = SW + 1;

  typedef enum logic [1:0] {StInit, StRun, StFull} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        sweep_q, sweep_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [LIST_SIZE-1:0] bitmap_q, bitmap_d;
  logic [IW-1:0]        owner_q [LIST_SIZE];
  logic [IW-1:0]        owner_d [LIST_SIZE];
  logic [CW-1:0]        free_count_q, free_count_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SW-1:0]        gnt_slot_q, gnt_slot_d;
  logic                 free_err_q, free_err_d;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        cand;
  logic                 slot_found;
  logic [SW-1:0]        slot_idx;
  logic                 free_hit;
  logic                 grant;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = IW'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int s = int'(LIST_SIZE) - 1; s >= 0; s--) begin
      if (!bitmap_q[s]) begin
        slot_found = 1'b1;
        slot_idx   = SW'(s);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    ptr_d        = ptr_q;
    bitmap_d     = bitmap_q;
    owner_d      = owner_q;
    free_count_d = free_count_q;
    gnt_d        = '0;
    gnt_slot_d   = '0;
    free_err_d   = 1'b0;
    free_hit     = 1'b0;
    grant        = 1'b0;

    case (state_q)
      StInit: begin
        bitmap_d[sweep_q] = 1'b0;
        owner_d[sweep_q]  = '0;
        if (sweep_q == SW'(LIST_SIZE - 1)) begin
          sweep_d      = '0;
          state_d      = StRun;
          free_count_d = CW'(LIST_SIZE);
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      StRun, StFull: begin
        free_hit = FREE_VALID && (int'(FREE_SLOT) < int'(LIST_SIZE)) &&
                   bitmap_q[FREE_SLOT] && (owner_q[FREE_SLOT] == FREE_ID);
        grant    = (state_q == StRun) && win_found && slot_found && (free_count_q != '0);
        // A freed slot is still set in bitmap_q, so it never collides with the grant slot.
        if (free_hit) begin
          bitmap_d[FREE_SLOT] = 1'b0;
        end else if (FREE_VALID) begin
          free_err_d = 1'b1;
        end
        if (grant) begin
          bitmap_d[slot_idx] = 1'b1;
          owner_d[slot_idx]  = win_idx;
          ptr_d              = win_idx;
          gnt_d[win_idx]     = 1'b1;
          gnt_slot_d         = slot_idx;
        end
        free_count_d = free_count_q + CW'(free_hit) - CW'(grant);
        if (state_q == StRun && grant && !free_hit && free_count_q == CW'(1)) begin
          state_d = StFull;
        end else if (state_q == StFull && free_hit) begin
          state_d = StRun;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      ptr_q        <= IW'(NUM_REQ - 1);
      free_count_q <= '0;
      gnt_q        <= '0;
      gnt_slot_q   <= '0;
      free_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ptr_q        <= ptr_d;
      bitmap_q     <= bitmap_d;
      owner_q      <= owner_d;
      free_count_q <= free_count_d;
      gnt_q        <= gnt_d;
      gnt_slot_q   <= gnt_slot_d;
      free_err_q   <= free_err_d;
    end
  end

  assign GNT        = gnt_q;
  assign GNT_SLOT   = gnt_slot_q;
  assign FREE_ERR   = free_err_q;
  assign FREE_COUNT = free_count_q;
  assign READY      = (state_q != StInit);

endmodule

// File: tb/tb_alloc_arbiter.sv
// Directed bench for alloc_arbiter (LIST_SIZE=8, NUM_REQ=4); outputs sampled 1ns after each edge.
module tb_alloc_arbiter;

  logic       CLK;
  logic       RSTN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [2:0] GNT_SLOT;
  logic       FREE_VALID;
  logic [1:0] FREE_ID;
  logic [2:0] FREE_SLOT;
  logic       FREE_ERR;
  logic [3:0] FREE_COUNT;
  logic       READY;

  int n_pass  = 0;
  int n_total = 0;

  alloc_arbiter #(.LIST_SIZE(8), .NUM_REQ(4)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .REQ       (REQ),
    .GNT       (GNT),
    .GNT_SLOT  (GNT_SLOT),
    .FREE_VALID(FREE_VALID),
    .FREE_ID   (FREE_ID),
    .FREE_SLOT (FREE_SLOT),
    .FREE_ERR  (FREE_ERR),
    .FREE_COUNT(FREE_COUNT),
    .READY     (READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bring_up();
    RSTN = 1'b0; REQ = '0; FREE_VALID = 1'b0; FREE_ID = '0; FREE_SLOT = '0;
    step(); step();
    RSTN = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_reset();
    RSTN = 1'b0; REQ = '0; FREE_VALID = 1'b0; FREE_ID = '0; FREE_SLOT = '0;
    step(); step();
    n_total++; if (GNT !== 4'b0) $display("FAIL reset_gnt got %b want 0000", GNT); else n_pass++;
    n_total++; if (GNT_SLOT !== 3'd0) $display("FAIL reset_slot got %0d want 0", GNT_SLOT); else n_pass++;
    n_total++; if (FREE_ERR !== 1'b0) $display("FAIL reset_err got %b want 0", FREE_ERR); else n_pass++;
    n_total++; if (FREE_COUNT !== 4'd0) $display("FAIL reset_cnt got %0d want 0", FREE_COUNT); else n_pass++;
    n_total++; if (READY !== 1'b0) $display("FAIL reset_ready got %b want 0", READY); else n_pass++;
    // Requests and frees during the sweep must be ignored.
    RSTN = 1'b1; REQ = 4'b1111; FREE_VALID = 1'b1; FREE_ID = 2'd0; FREE_SLOT = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_total++; if (READY !== 1'b0) $display("FAIL init_ready cyc %0d got %b want 0", k, READY); else n_pass++;
      n_total++; if (GNT !== 4'b0 || FREE_ERR !== 1'b0)
        $display("FAIL init_quiet cyc %0d got gnt %b err %b want 0000 0", k, GNT, FREE_ERR);
      else n_pass++;
    end
    REQ = '0; FREE_VALID = 1'b0;
    step();
    n_total++; if (READY !== 1'b1) $display("FAIL init_done_ready got %b want 1", READY); else n_pass++;
    n_total++; if (FREE_COUNT !== 4'd8) $display("FAIL init_done_cnt got %0d want 8", FREE_COUNT); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    bring_up();
    REQ = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_gnt = 4'b0001 << k;
      n_total++; if (GNT !== exp_gnt) $display("FAIL rr_gnt %0d got %b want %b", k, GNT, exp_gnt); else n_pass++;
      n_total++; if (GNT_SLOT !== 3'(k)) $display("FAIL rr_slot %0d got %0d want %0d", k, GNT_SLOT, k); else n_pass++;
      n_total++; if (FREE_COUNT !== 4'(7 - k)) $display("FAIL rr_cnt %0d got %0d want %0d", k, FREE_COUNT, 7 - k); else n_pass++;
    end
    REQ = '0;
    step();
    n_total++; if (GNT !== 4'b0) $display("FAIL rr_idle_gnt got %b want 0000", GNT); else n_pass++;
  endtask

  task automatic test_full();
    bring_up();
    REQ = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step();
      n_total++; if (GNT !== 4'b0001 || GNT_SLOT !== 3'(k))
        $display("FAIL fill_gnt %0d got %b/%0d want 0001/%0d", k, GNT, GNT_SLOT, k);
      else n_pass++;
    end
    step();
    n_total++; if (GNT !== 4'b0) $display("FAIL full_gnt got %b want 0000", GNT); else n_pass++;
    n_total++; if (FREE_COUNT !== 4'd0) $display("FAIL full_cnt got %0d want 0", FREE_COUNT); else n_pass++;
    n_total++; if (READY !== 1'b1) $display("FAIL full_ready got %b want 1", READY); else n_pass++;
    FREE_VALID = 1'b1; FREE_ID = 2'd0; FREE_SLOT = 3'd5;
    step();
    FREE_VALID = 1'b0;
    n_total++; if (FREE_COUNT !== 4'd1 || FREE_ERR !== 1'b0)
      $display("FAIL full_free got cnt %0d err %b want 1 0", FREE_COUNT, FREE_ERR);
    else n_pass++;
    n_total++; if (GNT !== 4'b0) $display("FAIL full_free_gnt got %b want 0000", GNT); else n_pass++;
    step();
    n_total++; if (GNT !== 4'b0001 || GNT_SLOT !== 3'd5)
      $display("FAIL refill got %b/%0d want 0001/5", GNT, GNT_SLOT);
    else n_pass++;
    n_total++; if (FREE_COUNT !== 4'd0) $display("FAIL refill_cnt got %0d want 0", FREE_COUNT); else n_pass++;
    step();
    n_total++; if (GNT !== 4'b0) $display("FAIL refull_gnt got %b want 0000", GNT); else n_pass++;
    REQ = '0;
  endtask

  task automatic test_free_err();
    bring_up();
    REQ = 4'b0001;
    step(); step();
    REQ = 4'b0010;
    step();
    REQ = '0;
    n_total++; if (GNT !== 4'b0010 || GNT_SLOT !== 3'd2)
      $display("FAIL own_gnt got %b/%0d want 0010/2", GNT, GNT_SLOT);
    else n_pass++;
    FREE_VALID = 1'b1; FREE_ID = 2'd3; FREE_SLOT = 3'd2;
    step();
    FREE_VALID = 1'b0;
    n_total++; if (FREE_ERR !== 1'b1) $display("FAIL wrong_owner_err got %b want 1", FREE_ERR); else n_pass++;
    n_total++; if (FREE_COUNT !== 4'd5) $display("FAIL wrong_owner_cnt got %0d want 5", FREE_COUNT); else n_pass++;
    step();
    n_total++; if (FREE_ERR !== 1'b0) $display("FAIL err_pulse got %b want 0", FREE_ERR); else n_pass++;
    FREE_VALID = 1'b1; FREE_ID = 2'd1; FREE_SLOT = 3'd6;
    step();
    n_total++; if (FREE_ERR !== 1'b1 || FREE_COUNT !== 4'd5)
      $display("FAIL unalloc_free got err %b cnt %0d want 1 5", FREE_ERR, FREE_COUNT);
    else n_pass++;
    FREE_SLOT = 3'd2;
    step();
    FREE_VALID = 1'b0;
    n_total++; if (FREE_ERR !== 1'b0 || FREE_COUNT !== 4'd6)
      $display("FAIL good_free got err %b cnt %0d want 0 6", FREE_ERR, FREE_COUNT);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bring_up();
    REQ = 4'b0001;
    step(); step();
    REQ = 4'b0100; FREE_VALID = 1'b1; FREE_ID = 2'd0; FREE_SLOT = 3'd0;
    step();
    FREE_VALID = 1'b0;
    n_total++; if (GNT !== 4'b0100 || GNT_SLOT !== 3'd2)
      $display("FAIL sim_gnt got %b/%0d want 0100/2", GNT, GNT_SLOT);
    else n_pass++;
    n_total++; if (FREE_COUNT !== 4'd6 || FREE_ERR !== 1'b0)
      $display("FAIL sim_cnt got cnt %0d err %b want 6 0", FREE_COUNT, FREE_ERR);
    else n_pass++;
    step();
    REQ = '0;
    n_total++; if (GNT !== 4'b0100 || GNT_SLOT !== 3'd0)
      $display("FAIL sim_reuse got %b/%0d want 0100/0", GNT, GNT_SLOT);
    else n_pass++;
    n_total++; if (FREE_COUNT !== 4'd5) $display("FAIL sim_reuse_cnt got %0d want 5", FREE_COUNT); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bring_up();
    REQ = 4'b0001;
    step(); step(); step();
    n_total++; if (FREE_COUNT !== 4'd5) $display("FAIL mid_pre_cnt got %0d want 5", FREE_COUNT); else n_pass++;
    RSTN = 1'b0; FREE_VALID = 1'b1; FREE_ID = 2'd0; FREE_SLOT = 3'd1;
    step();
    n_total++; if (GNT !== 4'b0 || GNT_SLOT !== 3'd0 || FREE_ERR !== 1'b0 ||
                   FREE_COUNT !== 4'd0 || READY !== 1'b0)
      $display("FAIL mid_reset got gnt %b slot %0d err %b cnt %0d rdy %b want all 0",
               GNT, GNT_SLOT, FREE_ERR, FREE_COUNT, READY);
    else n_pass++;
    RSTN = 1'b1; REQ = '0; FREE_VALID = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_total++; if (READY !== 1'b0) $display("FAIL mid_init_ready cyc %0d got %b want 0", k, READY); else n_pass++;
    end
    step();
    n_total++; if (READY !== 1'b1 || FREE_COUNT !== 4'd8)
      $display("FAIL mid_init_done got rdy %b cnt %0d want 1 8", READY, FREE_COUNT);
    else n_pass++;
    REQ = 4'b1111;
    step();
    REQ = '0;
    n_total++; if (GNT !== 4'b0001 || GNT_SLOT !== 3'd0)
      $display("FAIL mid_first_gnt got %b/%0d want 0001/0", GNT, GNT_SLOT);
    else n_pass++;
  endtask

  initial begin
    RSTN = 1'b0; REQ = '0; FREE_VALID = 1'b0; FREE_ID = '0; FREE_SLOT = '0;
    test_reset();
    test_round_robin();
    test_full();
    test_free_err();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alloc_arbiter.md
ALLOC_ARBITER -- requirements
Module: alloc_arbiter

Interface
REQ-001 Parameter LIST_SIZE, default 32: number of allocatable slots, 2..256.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RSTN  input  1  reset, synchronous, active-low.
REQ-005 REQ  input  NUM_REQ  per-requester allocation request, level.
REQ-006 GNT  output  NUM_REQ  one-hot grant, registered, one-cycle pulse.
REQ-007 GNT_SLOT  output  $clog2(LIST_SIZE)  slot index granted; valid only while GNT nonzero.
REQ-008 FREE_VALID  input  1  free request strobe.
REQ-009 FREE_ID  input  $clog2(NUM_REQ)  requester issuing the free.
REQ-010 FREE_SLOT  input  $clog2(LIST_SIZE)  slot to release.
REQ-011 FREE_ERR  output  1  registered one-cycle pulse: rejected free.
REQ-012 FREE_COUNT  output  $clog2(LIST_SIZE)+1  number of unallocated slots, registered.
REQ-013 READY  output  1  high in RUN and FULL states.

Function
REQ-014 Internal state: allocation bitmap (LIST_SIZE bits), owner table (LIST_SIZE x $clog2(NUM_REQ)), round-robin pointer, free counter, FSM {INIT, RUN, FULL}.
REQ-015 INIT: one slot per cycle cleared (bit=0, owner=0) by sweep counter; exactly LIST_SIZE cycles; REQ and FREE_VALID ignored; GNT, FREE_ERR held 0.
REQ-016 INIT -> RUN on final sweep cycle; FREE_COUNT loads LIST_SIZE on that same edge.
REQ-017 RUN: on each edge with any REQ bit set and FREE_COUNT>0, exactly one requester granted.
REQ-018 Arbitration: round-robin, search starting at index (pointer+1) mod NUM_REQ; pointer updated to granted index only on a grant.
REQ-019 Slot selection: lowest-index slot with bitmap bit 0, evaluated on pre-edge bitmap.
REQ-020 Grant edge: bitmap bit set, owner entry written with winner index, FREE_COUNT decremented; GNT/GNT_SLOT visible the following cycle (latency 1 from REQ sampled).
REQ-021 REQ held high after grant counts as new request; no per-requester limit.
REQ-022 Free accepted iff FREE_SLOT < LIST_SIZE, bitmap bit set, owner == FREE_ID; on accept bit cleared, FREE_COUNT incremented.
REQ-023 Free rejected otherwise: no state change, FREE_ERR pulses cycle after FREE_VALID.
REQ-024 Simultaneous grant and accepted free: both applied same edge; FREE_COUNT net unchanged; freed slot not eligible for the concurrent grant.
REQ-025 Simultaneous grant and free of same slot impossible (granted slot is free pre-edge, so that free rejects).
REQ-026 RUN -> FULL when grant without accepted free drives FREE_COUNT to 0.
REQ-027 FULL: no grants, pointer frozen, pending REQ stays pending; frees processed as in RUN.
REQ-028 FULL -> RUN on accepted free; grant first possible on the following edge.
REQ-029 FREE_COUNT never exceeds LIST_SIZE nor underflows below 0.

Reset
REQ-030 RSTN low at any edge: FSM to INIT with sweep counter 0, pointer = NUM_REQ-1, GNT=0, GNT_SLOT=0, FREE_ERR=0, FREE_COUNT=0, READY=0.
REQ-031 Reset mid-operation discards in-flight grants and frees; full INIT sweep repeats after RSTN returns high.

Verification
REQ-032 LIST_SIZE=8, NUM_REQ=4: release RSTN -> READY=0 for 8 cycles, then READY=1, FREE_COUNT=8.
REQ-033 REQ=4'b1111 held 4 cycles from RUN -> GNT 0001,0010,0100,1000 on successive cycles, GNT_SLOT 0,1,2,3, FREE_COUNT 4.
REQ-034 REQ[0] held 9 cycles -> slots 0..7 granted, FREE_COUNT 0, FSM FULL, GNT=0 on 9th; then FREE_ID=0,FREE_SLOT=5 -> FREE_COUNT 1, next grant GNT_SLOT=5.
REQ-035 Slot 2 owned by requester 1; FREE_ID=3,FREE_SLOT=2 -> FREE_ERR pulse, FREE_COUNT unchanged; FREE_SLOT of unallocated slot 6 -> FREE_ERR pulse.
REQ-036 Slots 0,1 allocated; same edge REQ[2]=1 and valid free of slot 0 -> GNT_SLOT=2, slot 0 then free, FREE_COUNT unchanged.
REQ-037 RSTN pulsed low while 3 slots allocated -> all outputs 0, 8-cycle INIT, then FREE_COUNT=8 and first grant GNT_SLOT=0 to requester 0.
